// File: rtl/writeback_stage_pkg.sv
// Shared widths, load-type encodings and the MEM/WB pipeline register layout
// used by the writeback stage.
package writeback_stage_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned REG_AW = 5;
   localparam int unsigned LT_W   = 3;
   localparam int unsigned CNT_W  = 32;

   localparam logic [LT_W-1:0] LT_LW  = 3'b000;
   localparam logic [LT_W-1:0] LT_LH  = 3'b001;
   localparam logic [LT_W-1:0] LT_LHU = 3'b010;
   localparam logic [LT_W-1:0] LT_LB  = 3'b011;
   localparam logic [LT_W-1:0] LT_LBU = 3'b100;

   typedef struct packed {
      logic              valid;
      logic              regwrite;
      logic              memtoreg;
      logic [LT_W-1:0]   load_type;
      logic [1:0]        addr_lo;
      logic [DATA_W-1:0] alu;
      logic [DATA_W-1:0] rdata;
      logic [REG_AW-1:0] dest;
      logic              fresh;
   } wb_reg_t;

endpackage

// File: rtl/writeback_stage_load_extend.sv
// Selects the addressed byte/half of a little-endian load word, extends it,
// and flags misaligned word/half accesses.
module load_extend
   import writeback_stage_pkg::*;
(
   input  logic [LT_W-1:0]   load_type,
   input  logic [1:0]        addr_lo,
   input  logic [DATA_W-1:0] rdata,
   output logic [DATA_W-1:0] data,
   output logic              misaligned
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel   = rdata[7:0];
      half_sel   = addr_lo[1] ? rdata[31:16] : rdata[15:0];
      data       = rdata;
      misaligned = (addr_lo != 2'd0);

      case (addr_lo)
         2'd1:    byte_sel = rdata[15:8];
         2'd2:    byte_sel = rdata[23:16];
         2'd3:    byte_sel = rdata[31:24];
         default: byte_sel = rdata[7:0];
      endcase

      // Reserved encodings fall through to word behaviour.
      case (load_type)
         LT_LH: begin
            data       = {{(DATA_W-16){half_sel[15]}}, half_sel};
            misaligned = addr_lo[0];
         end
         LT_LHU: begin
            data       = {{(DATA_W-16){1'b0}}, half_sel};
            misaligned = addr_lo[0];
         end
         LT_LB: begin
            data       = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
            misaligned = 1'b0;
         end
         LT_LBU: begin
            data       = {{(DATA_W-8){1'b0}}, byte_sel};
            misaligned = 1'b0;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/writeback_stage.sv
// MEM/WB pipeline register and register-file write port, with forwarding tap,
// sticky misaligned-load flag and retired-instruction counter.
module writeback_stage
   import writeback_stage_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              stall,
   input  logic              flush,
   input  logic              m_valid,
   input  logic              m_regwrite,
   input  logic              m_memtoreg,
   input  logic [LT_W-1:0]   m_load_type,
   input  logic [1:0]        m_addr_lo,
   input  logic [DATA_W-1:0] m_alu_result,
   input  logic [DATA_W-1:0] m_rdata,
   input  logic [REG_AW-1:0] m_dest,
   output logic              we3,
   output logic              v_f,
   output logic [REG_AW-1:0] a3,
   output logic [DATA_W-1:0] wd3,
   output logic              fwd_valid,
   output logic [REG_AW-1:0] fwd_dest,
   output logic [DATA_W-1:0] fwd_data,
   output logic              misalign_err,
   output logic [CNT_W-1:0]  retire_count
);

   wb_reg_t            wb_q, wb_d;
   logic               err_q, err_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [DATA_W-1:0]  ld_data;
   logic               ld_misaligned;
   logic               misaligned;
   logic               retiring;

   load_extend u_load_extend (
      .load_type  (wb_q.load_type),
      .addr_lo    (wb_q.addr_lo),
      .rdata      (wb_q.rdata),
      .data       (ld_data),
      .misaligned (ld_misaligned)
   );

   assign misaligned = wb_q.memtoreg & ld_misaligned;
   assign retiring   = wb_q.fresh & wb_q.valid;

   // Next-state: flush beats stall; fresh marks the first cycle an instruction sits in WB.
   always_comb begin
      wb_d  = wb_q;
      err_d = err_q | (retiring & misaligned);
      cnt_d = cnt_q + CNT_W'(retiring);
      if (flush) begin
         wb_d.valid = 1'b0;
         wb_d.fresh = 1'b0;
      end else if (stall) begin
         wb_d.fresh = 1'b0;
      end else begin
         wb_d.valid     = m_valid;
         wb_d.regwrite  = m_regwrite;
         wb_d.memtoreg  = m_memtoreg;
         wb_d.load_type = m_load_type;
         wb_d.addr_lo   = m_addr_lo;
         wb_d.alu       = m_alu_result;
         wb_d.rdata     = m_rdata;
         wb_d.dest      = m_dest;
         wb_d.fresh     = m_valid;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wb_q  <= '0;
         err_q <= 1'b0;
         cnt_q <= '0;
      end else begin
         wb_q  <= wb_d;
         err_q <= err_d;
         cnt_q <= cnt_d;
      end
   end

   assign we3 = retiring & wb_q.regwrite & (wb_q.dest != '0) & ~misaligned;
   assign v_f = wb_q.valid;
   assign a3  = wb_q.dest;
   assign wd3 = wb_q.memtoreg ? ld_data : wb_q.alu;

   assign fwd_valid    = we3;
   assign fwd_dest     = a3;
   assign fwd_data     = wd3;
   assign misalign_err = err_q;
   assign retire_count = cnt_q;

endmodule
